// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: ALU operation encodings and the multicycle ALU state set.
// The original seven ALU op codes keep their values; newer ops are appended after them.
package lc3b_types;

    typedef enum logic [4:0] {
        alu_add  = 5'd0,
        alu_and  = 5'd1,
        alu_not  = 5'd2,
        alu_pass = 5'd3,
        alu_sll  = 5'd4,
        alu_srl  = 5'd5,
        alu_sra  = 5'd6,
        alu_sub  = 5'd7,
        alu_or   = 5'd8,
        alu_xor  = 5'd9,
        alu_nand = 5'd10,
        alu_nor  = 5'd11,
        alu_xnor = 5'd12,
        alu_mult = 5'd13,
        alu_div  = 5'd14,
        alu_rem  = 5'd15
    } lc3b_aluop;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_mc_state_t;

    function automatic logic is_divrem(input lc3b_aluop op);
        return (op == alu_div) || (op == alu_rem);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned engine: WIDTH-step shift-add multiplier (mode=0) or restoring divider (mode=1).
// result/remainder show the value after the step in progress, so the caller can capture them when done is high.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic             mode_q;
    // acc: product accumulator / partial remainder; shf: multiplier / dividend-quotient; opd: multiplicand / divisor
    logic [WIDTH-1:0] acc, shf, opd;
    logic [WIDTH-1:0] acc_nx, shf_nx, opd_nx;
    logic [WIDTH:0]   r_shift, diff;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        acc_nx  = acc;
        shf_nx  = shf;
        opd_nx  = opd;
        r_shift = {acc, shf[WIDTH-1]};
        diff    = r_shift - {1'b0, opd};
        if (!mode_q) begin
            acc_nx = acc + (shf[0] ? opd : '0);
            shf_nx = shf >> 1;
            opd_nx = opd << 1;
        end else if (diff[WIDTH]) begin
            acc_nx = r_shift[WIDTH-1:0];
            shf_nx = {shf[WIDTH-2:0], 1'b0};
        end else begin
            acc_nx = diff[WIDTH-1:0];
            shf_nx = {shf[WIDTH-2:0], 1'b1};
        end
    end

    assign done      = busy && (count == CNT_W'(WIDTH - 1));
    assign result    = mode_q ? shf_nx : acc_nx;
    assign remainder = acc_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; busy gates every use, and start reloads them.
    always_ff @(posedge clk) begin
        if (start) begin
            mode_q <= mode;
            acc    <= '0;
            shf    <= mode ? a : b;
            opd    <= mode ? b : a;
        end else if (busy) begin
            acc <= acc_nx;
            shf <= shf_nx;
            opd <= opd_nx;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// LC-3b ALU with valid/ready request port: single-cycle ops answer next cycle, mult/div/rem iterate WIDTH steps.
// Holds the control FSM, the single-cycle op mux and the result register; iteration lives in alu_iter_muldiv.
module alu_multicycle
    import lc3b_types::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  lc3b_aluop        aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_dbz
);

    alu_mc_state_t    state, state_nx;
    logic             accept, b_zero, op_mul, op_divrem, start;
    logic             rem_sel, iter_done;
    logic [WIDTH-1:0] sc_result, iter_result, iter_rem;
    logic [SHAMT_W-1:0] shamt;

    assign accept    = req_valid & req_ready;
    assign b_zero    = (b == '0);
    assign op_mul    = (aluop == alu_mult);
    assign op_divrem = is_divrem(aluop);
    assign start     = accept & (op_mul | (op_divrem & ~b_zero));
    assign shamt     = b[SHAMT_W-1:0];

    // Divide-by-zero answers come from this mux too: all-ones for div, a for rem.
    always_comb begin
        sc_result = '0;
        case (aluop)
            alu_add:  sc_result = a + b;
            alu_sub:  sc_result = a - b;
            alu_and:  sc_result = a & b;
            alu_or:   sc_result = a | b;
            alu_xor:  sc_result = a ^ b;
            alu_nand: sc_result = ~(a & b);
            alu_nor:  sc_result = ~(a | b);
            alu_xnor: sc_result = ~(a ^ b);
            alu_not:  sc_result = ~a;
            alu_pass: sc_result = a;
            alu_sll:  sc_result = a << shamt;
            alu_srl:  sc_result = a >> shamt;
            alu_sra:  sc_result = $signed(a) >>> shamt;
            alu_div:  sc_result = '1;
            alu_rem:  sc_result = a;
            default:  sc_result = '0;
        endcase
    end

    // NOTE: state and result registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE, DONE: begin
                req_ready  = 1'b1;
                resp_valid = (state == DONE);
                if (!accept)                    state_nx = IDLE;
                else if (op_mul)                state_nx = MUL;
                else if (op_divrem && !b_zero)  state_nx = DIV;
                else                            state_nx = DONE;
            end
            MUL, DIV: begin
                if (iter_done) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data <= '0;
            resp_dbz  <= 1'b0;
            rem_sel   <= 1'b0;
        end else begin
            if (accept) rem_sel <= (aluop == alu_rem);
            if (accept && !start) begin
                resp_data <= sc_result;
                resp_dbz  <= op_divrem & b_zero;
            end else if (iter_done) begin
                resp_data <= rem_sel ? iter_rem : iter_result;
                resp_dbz  <= 1'b0;
            end
        end
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (op_divrem),
        .a         (a),
        .b         (b),
        .done      (iter_done),
        .result    (iter_result),
        .remainder (iter_rem)
    );

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: 16-bit and 32-bit instances, expected results queued at issue time.
module tb_alu_multicycle;
    import lc3b_types::*;

    typedef struct {
        logic [31:0] data;
        logic        dbz;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        rv16, rr16, sv16, sz16;
    lc3b_aluop   op16;
    logic [15:0] a16, b16, sd16;
    logic        rv32, rr32, sv32, sz32;
    lc3b_aluop   op32;
    logic [31:0] a32, b32, sd32;

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .req_valid(rv16), .req_ready(rr16), .aluop(op16),
        .a(a16), .b(b16), .resp_valid(sv16), .resp_data(sd16), .resp_dbz(sz16)
    );

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .req_valid(rv32), .req_ready(rr32), .aluop(op32),
        .a(a32), .b(b32), .resp_valid(sv32), .resp_data(sd32), .resp_dbz(sz32)
    );

    exp_t q16[$];
    exp_t q32[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void model(input int w, input lc3b_aluop op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, output logic [31:0] r, output logic dbz);
        logic [31:0] mask, a, b, sx;
        logic [63:0] p;
        int          sh;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        sh   = int'(b & 32'(w - 1));
        sx   = a[w-1] ? (a | ~mask) : a;
        dbz  = 1'b0;
        r    = '0;
        case (op)
            alu_add:  r = a + b;
            alu_sub:  r = a - b;
            alu_and:  r = a & b;
            alu_or:   r = a | b;
            alu_xor:  r = a ^ b;
            alu_nand: r = ~(a & b);
            alu_nor:  r = ~(a | b);
            alu_xnor: r = ~(a ^ b);
            alu_not:  r = ~a;
            alu_pass: r = a;
            alu_sll:  r = a << sh;
            alu_srl:  r = a >> sh;
            alu_sra:  r = 32'($signed(sx) >>> sh);
            alu_mult: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            alu_div:  if (b == 0) begin r = '1; dbz = 1'b1; end else r = a / b;
            alu_rem:  if (b == 0) begin r = a;  dbz = 1'b1; end else r = a % b;
            default:  r = '0;
        endcase
        r = r & mask;
    endfunction

    // Drive one request, hold it until accepted, and queue the expected response.
    task automatic issue(input bit w32, input lc3b_aluop op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, bm;
        logic        dbz;
        int          lat, waited;
        exp_t        e;
        bm = w32 ? b : (b & 32'h0000_FFFF);
        model(w32 ? 32 : 16, op, a, b, r, dbz);
        lat = ((op == alu_mult) || (is_divrem(op) && bm != 0)) ? (w32 ? 33 : 17) : 1;
        @(negedge clk);
        if (w32) begin rv32 = 1'b1; op32 = op; a32 = a; b32 = b; end
        else     begin rv16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        waited = 0;
        while (!(w32 ? rr32 : rr16) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check("req_ready timeout", 32'd0, 32'd1);
            rv16 = 1'b0;
            rv32 = 1'b0;
            return;
        end
        e = '{data: r, dbz: dbz, lat: lat, acc_cyc: cyc + 1};
        if (w32) q32.push_back(e); else q16.push_back(e);
        @(posedge clk);
        #1;
        if (w32) rv32 = 1'b0; else rv16 = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((q16.size() + q32.size()) != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain pending", 32'(q16.size() + q32.size()), 32'd0);
    endtask

    always @(negedge clk) begin : mon16
        exp_t e;
        if (sv16) begin
            if (q16.size() == 0) check("w16 spurious resp_valid", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                check("w16 resp_data", {16'b0, sd16}, e.data);
                check("w16 resp_dbz", {31'b0, sz16}, {31'b0, e.dbz});
                check("w16 latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (sv32) begin
            if (q32.size() == 0) check("w32 spurious resp_valid", 32'd1, 32'd0);
            else begin
                e = q32.pop_front();
                check("w32 resp_data", sd32, e.data);
                check("w32 resp_dbz", {31'b0, sz32}, {31'b0, e.dbz});
                check("w32 latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
            end
        end
    end

    initial begin
        reset = 1'b1;
        rv16 = 1'b0; op16 = alu_add; a16 = '0; b16 = '0;
        rv32 = 1'b0; op32 = alu_add; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset resp_valid", {31'b0, sv16}, 32'd0);
        check("reset resp_data", {16'b0, sd16}, 32'd0);
        check("reset resp_dbz", {31'b0, sz16}, 32'd0);
        reset = 1'b0;
        check("reset req_ready", {31'b0, rr16}, 32'd1);

        // Basic add overflow and subtract wrap
        issue(0, alu_add, 32'h7FFF, 32'h1);
        issue(0, alu_sub, 32'h0, 32'h1);
        drain();

        // Back-to-back single-cycle ops, one pulse per cycle
        issue(0, alu_and, 32'hF0F0, 32'h3C3C);
        issue(0, alu_or,  32'hF0F0, 32'h3C3C);
        issue(0, alu_xor, 32'hF0F0, 32'h3C3C);
        issue(0, alu_sra, 32'h8000, 32'h3);
        drain();

        // Multiply, with a request held while the engine is busy
        issue(0, alu_mult, 32'd300, 32'd300);
        @(negedge clk);
        check("req_ready during MUL", {31'b0, rr16}, 32'd0);
        issue(0, alu_add, 32'h1234, 32'h1111);
        drain();

        // Divide, remainder, divide by zero
        issue(0, alu_div, 32'd1000, 32'd7);
        issue(0, alu_rem, 32'd1000, 32'd7);
        issue(0, alu_div, 32'd5, 32'd0);
        issue(0, alu_rem, 32'd9, 32'd0);
        issue(0, lc3b_aluop'(5'd20), 32'h1234, 32'h5678);
        drain();

        // Every op with random operands, plus shift-amount edges
        for (int i = 0; i < 16; i++) begin
            issue(0, lc3b_aluop'(5'(i)), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
        end
        issue(0, alu_sll, 32'h0001, 32'd15);
        issue(0, alu_srl, 32'h8000, 32'd16);
        issue(0, alu_sra, 32'h8001, 32'd15);
        drain();

        // Reset in the middle of a divide: no response, fresh idle state
        issue(0, alu_div, 32'd1000, 32'd7);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        void'(q16.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("mid-div reset req_ready", {31'b0, rr16}, 32'd1);
        check("mid-div reset resp_data", {16'b0, sd16}, 32'd0);
        repeat (25) @(negedge clk);

        // Reset wins over a same-cycle request
        issue(0, alu_pass, 32'hABCD, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b1; rv16 = 1'b1; op16 = alu_pass; a16 = 16'h5555;
        @(negedge clk);
        reset = 1'b0; rv16 = 1'b0;
        check("reset+accept resp_data", {16'b0, sd16}, 32'd0);
        repeat (5) @(negedge clk);

        // 32-bit instance
        issue(1, alu_mult, 32'h0000_FFFF, 32'h0000_FFFF);
        issue(1, alu_sll, 32'h1, 32'd36);
        issue(1, alu_div, 32'hDEAD_BEEF, 32'd12345);
        issue(1, alu_rem, 32'hDEAD_BEEF, 32'd12345);
        issue(1, alu_sra, 32'h8000_0000, 32'd31);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
